// File: rtl/ula_result_fifo.sv
// Result FIFO behind the sequential ULA. It captures {carry, result}, hands entries out over valid/ready, and counts dropped pushes.
// Optional even-parity storage and the o_out_parity port are enabled with `define RESULT_PARITY_EN.
module ula_result_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_data_valid,
    input  logic [DATA_W-1:0]          i_data_result,
    input  logic                       i_data_carryout,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [DATA_W-1:0]          o_out_result,
    output logic                       o_out_carryout,
`ifdef RESULT_PARITY_EN
    output logic                       o_out_parity,
`endif
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_overflow,
    output logic [CNT_W-1:0]           o_drop_count,
    input  logic                       i_clr_overflow
);

    localparam int AW = $clog2(DEPTH);
`ifdef RESULT_PARITY_EN
    localparam int EW = DATA_W + 2;
`else
    localparam int EW = DATA_W + 1;
`endif
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    entryIn;
    logic [EW-1:0]    head;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             push, pop, drop;

`ifdef RESULT_PARITY_EN
    assign entryIn = {^{i_data_carryout, i_data_result}, i_data_carryout, i_data_result};
`else
    assign entryIn = {i_data_carryout, i_data_result};
`endif

    assign head    = mem[rd_ptr_q];
    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == FULL_COUNT);
    assign o_count = count_q;

    // Valid comes from registered occupancy only, so it never looks at i_out_ready.
    assign o_out_valid    = !o_empty;
    assign o_out_result   = o_out_valid ? head[DATA_W-1:0] : '0;
    assign o_out_carryout = o_out_valid ? head[DATA_W] : 1'b0;
`ifdef RESULT_PARITY_EN
    assign o_out_parity   = o_out_valid ? head[DATA_W+1] : 1'b0;
`endif

    assign pop  = o_out_valid & i_out_ready;
    assign push = i_data_valid & (!o_full | pop);
    assign drop = i_data_valid & o_full & !pop;

    assign o_overflow   = overflow_q;
    assign o_drop_count = drop_cnt_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear restarts the tally at one.
        if (drop) begin
            overflow_d = 1'b1;
            if (i_clr_overflow)
                drop_cnt_d = CNT_W'(1);
            else if (drop_cnt_q != '1)
                drop_cnt_d = drop_cnt_q + 1'b1;
        end else if (i_clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push)
            mem[wr_ptr_q] <= entryIn;
    end

endmodule

// File: tb/tb_ula_result_fifo.sv
// Scoreboard bench for ula_result_fifo. Stimulus queues the expected entries, and a negedge monitor compares every popped head.
// Parity checks run only when RESULT_PARITY_EN is defined.
module tb_ula_result_fifo;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_data_valid;
    logic [DATA_W-1:0] i_data_result;
    logic              i_data_carryout;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [DATA_W-1:0] o_out_result;
    logic              o_out_carryout;
`ifdef RESULT_PARITY_EN
    logic              o_out_parity;
`endif
    logic [3:0]        o_count;
    logic              o_full;
    logic              o_empty;
    logic              o_overflow;
    logic [CNT_W-1:0]  o_drop_count;
    logic              i_clr_overflow;

    int checks   = 0;
    int failures = 0;
    logic [DATA_W:0] sbQueue[$];

    ula_result_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_data_valid   (i_data_valid),
        .i_data_result  (i_data_result),
        .i_data_carryout(i_data_carryout),
        .o_out_valid    (o_out_valid),
        .i_out_ready    (i_out_ready),
        .o_out_result   (o_out_result),
        .o_out_carryout (o_out_carryout),
`ifdef RESULT_PARITY_EN
        .o_out_parity   (o_out_parity),
`endif
        .o_count        (o_count),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_overflow     (o_overflow),
        .o_drop_count   (o_drop_count),
        .i_clr_overflow (i_clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic carry, input bit accepted);
        i_data_valid    = 1'b1;
        i_data_result   = data;
        i_data_carryout = carry;
        if (accepted) sbQueue.push_back({carry, data});
        stepCycle();
        i_data_valid = 1'b0;
    endtask

    task automatic drainAll(input string name);
        i_out_ready = 1'b1;
        for (int k = 0; k < 4 * DEPTH; k++) begin
            if (o_empty) break;
            stepCycle();
        end
        i_out_ready = 1'b0;
        checkOutput({name, "_drained_empty"}, 64'(o_empty), 64'd1);
        checkOutput({name, "_sb_empty"}, 64'(sbQueue.size()), 64'd0);
    endtask

    // Handshake happens on the next rising edge, so the head seen here is the entry being popped.
    always @(negedge clk) begin
        if (o_out_valid && i_out_ready) begin
            if (sbQueue.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pop: got 0x%0h expected no entry", o_out_result);
            end else begin
                logic [DATA_W:0] exp;
                exp = sbQueue.pop_front();
                checkOutput("pop_result", 64'(o_out_result), 64'(exp[DATA_W-1:0]));
                checkOutput("pop_carry", 64'(o_out_carryout), 64'(exp[DATA_W]));
            end
        end
    end

    initial begin
        rst = 1'b0;
        i_data_valid = 1'b1;
        i_data_result = 32'hFFFF_FFFF;
        i_data_carryout = 1'b1;
        i_out_ready = 1'b0;
        i_clr_overflow = 1'b0;

        // Test 1: held in reset while upstream pushes.
        repeat (3) stepCycle();
        checkOutput("rst_empty", 64'(o_empty), 64'd1);
        checkOutput("rst_valid", 64'(o_out_valid), 64'd0);
        checkOutput("rst_count", 64'(o_count), 64'd0);
        checkOutput("rst_full", 64'(o_full), 64'd0);
        checkOutput("rst_result", 64'(o_out_result), 64'd0);
        checkOutput("rst_carry", 64'(o_out_carryout), 64'd0);
        checkOutput("rst_overflow", 64'(o_overflow), 64'd0);
        checkOutput("rst_drops", 64'(o_drop_count), 64'd0);
        i_data_valid = 1'b0;
        rst = 1'b1;
        stepCycle();

        // Test 2: a single entry becomes visible after one edge.
        applyStimulus(32'h0000_1234, 1'b0, 1'b1);
        checkOutput("t2_valid", 64'(o_out_valid), 64'd1);
        checkOutput("t2_result", 64'(o_out_result), 64'h1234);
        checkOutput("t2_count", 64'(o_count), 64'd1);
        i_out_ready = 1'b1;
        stepCycle();
        i_out_ready = 1'b0;
        checkOutput("t2_empty", 64'(o_empty), 64'd1);

        // Test 3: ten pushes into eight slots.
        for (int i = 0; i < 10; i++)
            applyStimulus(DATA_W'(i), 1'(i % 2), i < DEPTH);
        checkOutput("t3_full", 64'(o_full), 64'd1);
        checkOutput("t3_count", 64'(o_count), 64'd8);
        checkOutput("t3_overflow", 64'(o_overflow), 64'd1);
        checkOutput("t3_drops", 64'(o_drop_count), 64'd2);

        // Test 4: push and pop together while full.
        i_out_ready = 1'b1;
        applyStimulus(32'h0000_AAAA, 1'b0, 1'b1);
        i_out_ready = 1'b0;
        checkOutput("t4_count", 64'(o_count), 64'd8);
        checkOutput("t4_drops", 64'(o_drop_count), 64'd2);
        drainAll("t4");

        // Test 5: clear alone, then clear together with a drop, then saturation.
        i_clr_overflow = 1'b1;
        stepCycle();
        i_clr_overflow = 1'b0;
        checkOutput("t5_clr_overflow", 64'(o_overflow), 64'd0);
        checkOutput("t5_clr_drops", 64'(o_drop_count), 64'd0);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(DATA_W'(32'h100 + i), 1'b1, 1'b1);
        i_clr_overflow = 1'b1;
        applyStimulus(32'h0000_DEAD, 1'b0, 1'b0);
        i_clr_overflow = 1'b0;
        checkOutput("t5_setwins_overflow", 64'(o_overflow), 64'd1);
        checkOutput("t5_setwins_drops", 64'(o_drop_count), 64'd1);
        i_data_valid = 1'b1;
        repeat (260) stepCycle();
        i_data_valid = 1'b0;
        checkOutput("t5_saturate", 64'(o_drop_count), 64'd255);
        checkOutput("t5_still_full", 64'(o_count), 64'd8);
        i_clr_overflow = 1'b1;
        stepCycle();
        i_clr_overflow = 1'b0;
        checkOutput("t5_clr_after_sat", 64'(o_drop_count), 64'd0);
        drainAll("t5");

        // Test 6: asynchronous reset in the middle of the stream.
        applyStimulus(32'h0000_0011, 1'b0, 1'b1);
        applyStimulus(32'h0000_0022, 1'b1, 1'b1);
        applyStimulus(32'h0000_0033, 1'b0, 1'b1);
        checkOutput("t6_count3", 64'(o_count), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        sbQueue.delete();
        checkOutput("t6_async_valid", 64'(o_out_valid), 64'd0);
        checkOutput("t6_async_count", 64'(o_count), 64'd0);
        checkOutput("t6_async_result", 64'(o_out_result), 64'd0);
        stepCycle();
        rst = 1'b1;
        applyStimulus(32'h0000_BEEF, 1'b1, 1'b1);
        checkOutput("t6_head", 64'(o_out_result), 64'hBEEF);
        checkOutput("t6_carry", 64'(o_out_carryout), 64'd1);
        checkOutput("t6_count1", 64'(o_count), 64'd1);
`ifdef RESULT_PARITY_EN
        checkOutput("t6_parity_beef", 64'(o_out_parity), 64'd0);
`endif
        drainAll("t6");

        applyStimulus(32'h0000_0007, 1'b0, 1'b1);
`ifdef RESULT_PARITY_EN
        checkOutput("t7_parity", 64'(o_out_parity), 64'd1);
`endif
        checkOutput("t7_head", 64'(o_out_result), 64'h7);
        drainAll("t7");
`ifdef RESULT_PARITY_EN
        checkOutput("t7_parity_empty", 64'(o_out_parity), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
